// File: rtl/bcd_to_bin.sv
// Sequential BCD->binary converter (reverse double-dabble, one bit per clock) with start/busy/done handshake.
// Optional compare output (limit/over) enabled by defining BCD2BIN_CMP_EN.
module bcd_to_bin #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
`ifdef BCD2BIN_CMP_EN
    ,
    input  logic [BIN_W-1:0]      limit,
    output logic                  over
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SH_W  = 2 * BCD_W;
    localparam int unsigned CNT_W = (BCD_W > 1) ? $clog2(BCD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [SH_W-1:0]    r_sh;
    logic [CNT_W-1:0]   r_cnt;

    logic [SH_W-1:0]    w_sh_shr;
    logic [SH_W-1:0]    w_sh_nxt;
    logic               w_bad;
    logic [BIN_W-1:0]   w_bin;

    // One shift step: move right, then pull 3 out of every BCD nibble that reached 8 or more.
    always_comb begin
        w_sh_shr = r_sh >> 1;
        w_sh_nxt = w_sh_shr;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (w_sh_shr[BCD_W + 4*d + 3]) begin
                w_sh_nxt[BCD_W + 4*d +: 4] = w_sh_shr[BCD_W + 4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    assign w_bin = BIN_W'(r_sh[BCD_W-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
`ifdef BCD2BIN_CMP_EN
            over    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (w_bad) begin
                            err     <= 1'b1;
                            bin_out <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_sh    <= {bcd_in, BCD_W'(0)};
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            err     <= 1'b0;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sh  <= w_sh_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BCD_W - 1)) begin
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (!err) begin
                        bin_out <= w_bin;
                    end
`ifdef BCD2BIN_CMP_EN
                    over <= !err && (w_bin > limit);
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: stimulus pushes expected results, a negedge monitor pops on done.
// Expected values come from decimal arithmetic on the digits, not from the shift algorithm.
module tb_bcd_to_bin;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned BIN_W  = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [BCD_W-1:0]   bcd_in = '0;
    logic               busy;
    logic               done;
    logic               err;
    logic [BIN_W-1:0]   bin_out;
    logic [BIN_W-1:0]   limit = '0;
`ifdef BCD2BIN_CMP_EN
    logic               over;
`endif

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
`ifdef BCD2BIN_CMP_EN
        ,
        .limit   (limit),
        .over    (over)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned bin;
        bit          er;
        bit          ov;
        int unsigned lat;
        int unsigned e0;
        int unsigned bsy;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int unsigned model_bin = 0;
    bit          model_err = 1'b0;
    bit          prev_done = 1'b0;
    int unsigned busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse, checks held result between pulses.
    always @(negedge clk) begin
        if (!rst) begin
            prev_done = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                chk("done_width", 32'(prev_done), 0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bin_out", 32'(bin_out), e.bin);
                    chk("err", 32'(err), 32'(e.er));
                    chk("latency", cyc - e.e0, e.lat);
                    chk("busy_cycles", busy_cnt, e.bsy);
`ifdef BCD2BIN_CMP_EN
                    chk("over", 32'(over), 32'(e.ov));
`endif
                    model_bin = e.bin;
                    model_err = e.er;
                end
                busy_cnt = 0;
            end else begin
                chk("bin_hold", 32'(bin_out), model_bin);
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_bin"}, 32'(bin_out), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 1, 0);
            q.delete();
        end
    endtask

    // Issue one accepted request; expected result from decimal digit arithmetic.
    task automatic do_conv(input logic [BCD_W-1:0] b, input logic [BIN_W-1:0] lim, input bit wait_done);
        exp_t        e;
        int unsigned val;
        bit          bad;
        logic [3:0]  dg;
        logic [BCD_W-1:0] bb;
        bb  = b;
        val = 0;
        bad = 1'b0;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            dg  = bb[4*d +: 4];
            if (dg > 4'd9) bad = 1'b1;
            val = val * 10 + 32'(dg);
        end
        chk("err_held", 32'(err), 32'(model_err));
        start  = 1'b1;
        bcd_in = b;
        limit  = lim;
        tick();
        start  = 1'b0;
        bcd_in = BCD_W'($urandom);
        e.e0   = cyc;
        e.er   = bad;
        e.bin  = bad ? 0 : val;
        e.ov   = !bad && (val > 32'(lim));
        e.lat  = bad ? 1 : BCD_W + 1;
        e.bsy  = bad ? 0 : BCD_W;
        if (bad) model_bin = 0;
        q.push_back(e);
        if (wait_done) drain();
    endtask

    task automatic gap(input int unsigned n);
        for (int i = 0; i < int'(n); i++) tick();
    endtask

    initial begin
        logic [BCD_W-1:0] rb;
        rst = 1'b0;
        gap(3);
        check_idle("rst_low");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("idle");
        end

        do_conv(12'h999, 10'd500, 1'b1);
        gap(1);
        do_conv(12'h345, 10'd500, 1'b1);
        do_conv(12'h000, 10'd500, 1'b1);
        gap(2);
        do_conv(12'h0A5, 10'd500, 1'b1);
        gap(3);
        do_conv(12'h007, 10'd500, 1'b1);

        // Start pulse during an active conversion must be dropped.
        do_conv(12'h345, 10'd100, 1'b0);
        gap(4);
        start  = 1'b1;
        bcd_in = 12'h111;
        tick();
        start  = 1'b0;
        drain();
        gap(20);

        do_conv(12'h501, 10'd500, 1'b1);
        do_conv(12'h500, 10'd500, 1'b1);
        do_conv(12'hF00, 10'd0, 1'b1);

        // Reset during conversion aborts with no done pulse.
        do_conv(12'h999, 10'd500, 1'b0);
        gap(5);
        rst = 1'b0;
        #1;
        check_idle("abort");
        q.delete();
        model_bin = 0;
        model_err = 1'b0;
        gap(2);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
        end

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rb = BCD_W'($urandom);
            end else begin
                for (int d = 0; d < int'(DIGITS); d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            do_conv(rb, BIN_W'($urandom_range(0, 999)), 1'b1);
            gap($urandom_range(0, 2));
        end
        gap(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
